cpu_core: RTL and testbench

- Parametrised multi-cycle successor to the single-cycle CPU.
- Fetches each instruction from an external instruction memory over a req/valid handshake, then executes it and writes back the result. Each instruction takes one FETCH phase and one EXEC cycle.
- Adds the following beyond the previous core:
  - generic register-count and width parameters;
  - stall-tolerant fetch;
  - SUB, conditional branch and register jump;
  - HALT state;
  - debug register read port.
- Sits between the board top level (switches, LEDs) and the instruction ROM.

---
 rtl/cpu_pkg.sv | 51 +++++
 rtl/cpu_alu.sv | 61 ++++++
 rtl/cpu_core.sv | 191 +++++++++++++++++++
 tb/tb_cpu_core.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_pkg
//  Purpose  : Opcodes, FSM state codes and instruction-field helpers shared by
//             cpu_core and cpu_alu.
//  Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int unsigned c_OP_NOP        = 0;
    localparam int unsigned c_OP_ADD        = 1;
    localparam int unsigned c_OP_SUB        = 2;
    localparam int unsigned c_OP_LSHIFT     = 3;
    localparam int unsigned c_OP_RSHIFT     = 4;
    localparam int unsigned c_OP_INC        = 5;
    localparam int unsigned c_OP_DEC        = 6;
    localparam int unsigned c_OP_LOAD       = 7;
    localparam int unsigned c_OP_LOADSWITCH = 8;
    localparam int unsigned c_OP_JUMP       = 9;
    localparam int unsigned c_OP_JUMPREG    = 10;
    localparam int unsigned c_OP_BZ         = 11;
    localparam int unsigned c_OP_HALT       = 12;
    localparam int unsigned c_OP_SOFTRESET  = 13;

    localparam logic [1:0] c_ST_FETCH  = 2'd0;
    localparam logic [1:0] c_ST_EXEC   = 2'd1;
    localparam logic [1:0] c_ST_HALTED = 2'd2;

    // Instruction layout, msb to lsb: {opcode, rd, rs1, rs2, imm}
    function automatic int instr_width(input int ow, input int rw, input int nregs);
        return ow + 3 * $clog2(nregs) + rw;
    endfunction

    function automatic int rs2_lsb(input int rw);
        return rw;
    endfunction

    function automatic int rs1_lsb(input int rw, input int sw);
        return rw + sw;
    endfunction

    function automatic int rd_lsb(input int rw, input int sw);
        return rw + 2 * sw;
    endfunction

    function automatic int op_lsb(input int rw, input int sw);
        return rw + 3 * sw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_alu.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_alu
//  Purpose  : Combinational datapath producing the register writeback value
//             and its enable for every opcode.
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int REGISTER_WIDTH = 8,
    parameter int OPCODE_WIDTH   = 4,
    parameter int INPUT_WIDTH    = 8
) (
    input  logic [OPCODE_WIDTH-1:0]   opcode,
    input  logic [REGISTER_WIDTH-1:0] operandA,
    input  logic [REGISTER_WIDTH-1:0] operandB,
    input  logic [REGISTER_WIDTH-1:0] imm,
    input  logic [INPUT_WIDTH-1:0]    switch,
    output logic [REGISTER_WIDTH-1:0] result,
    output logic                      writeEnable
);

    localparam logic [REGISTER_WIDTH-1:0] c_ONE = REGISTER_WIDTH'(1);

    logic [31:0]               w_op;
    logic [REGISTER_WIDTH-1:0] w_switchExt;

    assign w_op = 32'(opcode);

    generate
        if (INPUT_WIDTH >= REGISTER_WIDTH) begin : g_sw_trunc
            assign w_switchExt = switch[REGISTER_WIDTH-1:0];
            if (INPUT_WIDTH > REGISTER_WIDTH) begin : g_sw_drop
                logic w_unused_switchHigh;
                assign w_unused_switchHigh = ^switch[INPUT_WIDTH-1:REGISTER_WIDTH];
            end
        end else begin : g_sw_zext
            assign w_switchExt = {{(REGISTER_WIDTH-INPUT_WIDTH){1'b0}}, switch};
        end
    endgenerate

    // Control-flow, HALT, SOFTRESET and undefined opcodes never write a register
    always_comb begin
        result      = '0;
        writeEnable = 1'b1;
        case (w_op)
            c_OP_ADD:        result = operandA + operandB;
            c_OP_SUB:        result = operandA - operandB;
            c_OP_LSHIFT:     result = operandA << 1;
            c_OP_RSHIFT:     result = operandA >> 1;
            c_OP_INC:        result = operandA + c_ONE;
            c_OP_DEC:        result = operandA - c_ONE;
            c_OP_LOAD:       result = imm;
            c_OP_LOADSWITCH: result = w_switchExt;
            default:         writeEnable = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cpu_core.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_core
//  Purpose  : Multi-cycle FETCH/EXEC core with handshake instruction fetch,
//             register file, HALT state and debug read port.
//             Define CPU_CORE_STEP_EN to add single-step control (stepPulse).
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_core
    import cpu_pkg::*;
#(
    parameter int REGISTER_WIDTH      = 8,
    parameter int NUMBER_OF_REGISTERS = 8,
    parameter int PC_WIDTH            = 8,
    parameter int OPCODE_WIDTH        = 4,
    parameter int INPUT_WIDTH         = 8
) (
    input  logic                                   clock,
    input  logic                                   isResetN,
    output logic                                   imemReq,
    output logic [PC_WIDTH-1:0]                    imemAddr,
    input  logic                                   imemValid,
    input  logic [instr_width(OPCODE_WIDTH, REGISTER_WIDTH, NUMBER_OF_REGISTERS)-1:0] imemData,
    input  logic [INPUT_WIDTH-1:0]                 switch,
`ifdef CPU_CORE_STEP_EN
    input  logic                                   stepPulse,
`endif
    input  logic [$clog2(NUMBER_OF_REGISTERS)-1:0] debugSel,
    output logic [REGISTER_WIDTH-1:0]              debugValue,
    output logic [PC_WIDTH-1:0]                    pc,
    output logic                                   retired,
    output logic                                   halted
);

    localparam int c_SEL_W   = $clog2(NUMBER_OF_REGISTERS);
    localparam int c_INSTR_W = instr_width(OPCODE_WIDTH, REGISTER_WIDTH, NUMBER_OF_REGISTERS);
    localparam int c_RS2_LSB = rs2_lsb(REGISTER_WIDTH);
    localparam int c_RS1_LSB = rs1_lsb(REGISTER_WIDTH, c_SEL_W);
    localparam int c_RD_LSB  = rd_lsb(REGISTER_WIDTH, c_SEL_W);
    localparam int c_OP_LSB  = op_lsb(REGISTER_WIDTH, c_SEL_W);
    localparam logic [PC_WIDTH-1:0] c_PC_ONE = PC_WIDTH'(1);

    logic [1:0]                r_state;
    logic [PC_WIDTH-1:0]       r_pc;
    logic [c_INSTR_W-1:0]      r_instr;
    logic [REGISTER_WIDTH-1:0] r_regs [NUMBER_OF_REGISTERS];

    logic [OPCODE_WIDTH-1:0]   w_opField;
    logic [31:0]               w_op;
    logic [c_SEL_W-1:0]        w_rd;
    logic [c_SEL_W-1:0]        w_rs1;
    logic [c_SEL_W-1:0]        w_rs2;
    logic [REGISTER_WIDTH-1:0] w_imm;
    logic [REGISTER_WIDTH-1:0] w_rs1Val;
    logic [REGISTER_WIDTH-1:0] w_rs2Val;
    logic [REGISTER_WIDTH-1:0] w_aluResult;
    logic                      w_aluWe;
    logic [PC_WIDTH-1:0]       w_immPc;
    logic [PC_WIDTH-1:0]       w_rs2Pc;
    logic [PC_WIDTH-1:0]       w_pcNext;
    logic [1:0]                w_stateNext;
    logic                      w_clearRegs;
    logic                      w_fetchGo;
    logic                      w_accept;

    assign w_opField = r_instr[c_OP_LSB +: OPCODE_WIDTH];
    assign w_op      = 32'(w_opField);
    assign w_rd      = r_instr[c_RD_LSB +: c_SEL_W];
    assign w_rs1     = r_instr[c_RS1_LSB +: c_SEL_W];
    assign w_rs2     = r_instr[c_RS2_LSB +: c_SEL_W];
    assign w_imm     = r_instr[0 +: REGISTER_WIDTH];
    assign w_rs1Val  = r_regs[w_rs1];
    assign w_rs2Val  = r_regs[w_rs2];

    generate
        if (PC_WIDTH > REGISTER_WIDTH) begin : g_pc_zext
            assign w_immPc = {{(PC_WIDTH-REGISTER_WIDTH){1'b0}}, w_imm};
            assign w_rs2Pc = {{(PC_WIDTH-REGISTER_WIDTH){1'b0}}, w_rs2Val};
        end else begin : g_pc_trunc
            assign w_immPc = w_imm[PC_WIDTH-1:0];
            assign w_rs2Pc = w_rs2Val[PC_WIDTH-1:0];
        end
    endgenerate

    cpu_alu #(
        .REGISTER_WIDTH (REGISTER_WIDTH),
        .OPCODE_WIDTH   (OPCODE_WIDTH),
        .INPUT_WIDTH    (INPUT_WIDTH)
    ) u_alu (
        .opcode      (w_opField),
        .operandA    (w_rs1Val),
        .operandB    (w_rs2Val),
        .imm         (w_imm),
        .switch      (switch),
        .result      (w_aluResult),
        .writeEnable (w_aluWe)
    );

    always_comb begin
        w_pcNext    = r_pc + c_PC_ONE;
        w_stateNext = c_ST_FETCH;
        w_clearRegs = 1'b0;
        case (w_op)
            c_OP_JUMP:    w_pcNext = w_immPc;
            c_OP_JUMPREG: w_pcNext = w_rs2Pc;
            c_OP_BZ: begin
                if (w_rs1Val == '0) begin
                    w_pcNext = w_immPc;
                end
            end
            c_OP_HALT: begin
                w_pcNext    = r_pc;
                w_stateNext = c_ST_HALTED;
            end
            c_OP_SOFTRESET: begin
                w_pcNext    = '0;
                w_clearRegs = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef CPU_CORE_STEP_EN
    // One-deep step token: consumed by a fetch, re-armed by any pulse
    logic r_stepToken;

    always_ff @(posedge clock or negedge isResetN) begin
        if (!isResetN) begin
            r_stepToken <= 1'b0;
        end else begin
            r_stepToken <= (r_stepToken && !w_accept) || stepPulse;
        end
    end

    assign w_fetchGo = r_stepToken;
`else
    assign w_fetchGo = 1'b1;
`endif

    // Gated by reset so the request is low for the whole reset interval
    assign imemReq  = isResetN && (r_state == c_ST_FETCH) && w_fetchGo;
    assign w_accept = imemReq && imemValid;

    always_ff @(posedge clock or negedge isResetN) begin
        if (!isResetN) begin
            r_state <= c_ST_FETCH;
            r_pc    <= '0;
            r_instr <= '0;
        end else begin
            case (r_state)
                c_ST_FETCH: begin
                    if (w_accept) begin
                        r_instr <= imemData;
                        r_state <= c_ST_EXEC;
                    end
                end
                c_ST_EXEC: begin
                    r_pc    <= w_pcNext;
                    r_state <= w_stateNext;
                end
                c_ST_HALTED: ;
                default: r_state <= c_ST_FETCH;
            endcase
        end
    end

    // Register 0 is never written, so it stays at its reset value of zero
    always_ff @(posedge clock or negedge isResetN) begin
        if (!isResetN) begin
            for (int i = 0; i < NUMBER_OF_REGISTERS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (r_state == c_ST_EXEC) begin
            if (w_clearRegs) begin
                for (int i = 0; i < NUMBER_OF_REGISTERS; i++) begin
                    r_regs[i] <= '0;
                end
            end else if (w_aluWe && (w_rd != '0)) begin
                r_regs[w_rd] <= w_aluResult;
            end
        end
    end

    assign imemAddr   = r_pc;
    assign pc         = r_pc;
    assign retired    = (r_state == c_ST_EXEC);
    assign halted     = (r_state == c_ST_HALTED);
    assign debugValue = r_regs[debugSel];

endmodule
`default_nettype wire

// File: tb/tb_cpu_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_core
//  Purpose  : Self-checking bench for cpu_core against an instruction-level
//             reference model, with directed programs and random programs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_core;

    localparam int OP_NOP = 0, OP_ADD = 1, OP_SUB = 2, OP_LSHIFT = 3, OP_RSHIFT = 4;
    localparam int OP_INC = 5, OP_DEC = 6, OP_LOAD = 7, OP_LOADSWITCH = 8, OP_JUMP = 9;
    localparam int OP_JUMPREG = 10, OP_BZ = 11, OP_HALT = 12, OP_SOFTRESET = 13;
    localparam int PH_FETCH = 0, PH_EXEC = 1, PH_HALT = 2;

    logic        clock = 1'b0;
    logic        isResetN;
    logic        imemReq;
    logic [7:0]  imemAddr;
    logic        imemValid;
    logic [20:0] imemData;
    logic [7:0]  switch;
    logic [2:0]  debugSel;
    logic [7:0]  debugValue;
    logic [7:0]  pc;
    logic        retired;
    logic        halted;

    cpu_core #(
        .REGISTER_WIDTH      (8),
        .NUMBER_OF_REGISTERS (8),
        .PC_WIDTH            (8),
        .OPCODE_WIDTH        (4),
        .INPUT_WIDTH         (8)
    ) dut (
        .clock      (clock),
        .isResetN   (isResetN),
        .imemReq    (imemReq),
        .imemAddr   (imemAddr),
        .imemValid  (imemValid),
        .imemData   (imemData),
        .switch     (switch),
        .debugSel   (debugSel),
        .debugValue (debugValue),
        .pc         (pc),
        .retired    (retired),
        .halted     (halted)
    );

    always #10 clock = ~clock;

    logic [20:0] rom [256];
    int          m_regs [8];
    int          m_pc;
    int          m_phase;
    logic [20:0] m_instr;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          vmode;
    bit          randSw;
    int          stallCnt;
    bit          prevStall;
    logic [7:0]  prevAddr;
    int          retireCount;
    int          haltCycle;
    int          trace [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [20:0] enc(input int op, input int rd, input int rs1,
                                        input int rs2, input int imm);
        return {4'(op), 3'(rd), 3'(rs1), 3'(rs2), 8'(imm)};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = '0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 0;
        m_pc    = 0;
        m_phase = PH_FETCH;
        m_instr = '0;
    endtask

    task automatic wr(input int rd, input int v);
        if (rd != 0) m_regs[rd] = v & 255;
    endtask

    // Instruction-level semantics: one call executes the latched instruction
    task automatic model_exec();
        int op, rd, rs1, rs2, imm, a, b, npc;
        op  = int'(m_instr[20:17]);
        rd  = int'(m_instr[16:14]);
        rs1 = int'(m_instr[13:11]);
        rs2 = int'(m_instr[10:8]);
        imm = int'(m_instr[7:0]);
        a   = m_regs[rs1];
        b   = m_regs[rs2];
        npc = (m_pc + 1) % 256;
        m_phase = PH_FETCH;
        case (op)
            OP_ADD:        wr(rd, a + b);
            OP_SUB:        wr(rd, a - b);
            OP_LSHIFT:     wr(rd, a * 2);
            OP_RSHIFT:     wr(rd, a / 2);
            OP_INC:        wr(rd, a + 1);
            OP_DEC:        wr(rd, a - 1);
            OP_LOAD:       wr(rd, imm);
            OP_LOADSWITCH: wr(rd, int'(switch));
            OP_JUMP:       npc = imm;
            OP_JUMPREG:    npc = b;
            OP_BZ:         if (a == 0) npc = imm;
            OP_HALT: begin
                npc     = m_pc;
                m_phase = PH_HALT;
            end
            OP_SOFTRESET: begin
                for (int i = 0; i < 8; i++) m_regs[i] = 0;
                npc = 0;
            end
            default: ;
        endcase
        m_pc = npc;
    endtask

    // Drive inputs for the coming edge, then advance the model across it
    task automatic step_inputs();
        imemData = rom[imemAddr];
        case (vmode)
            0: imemValid = 1'b1;
            1: imemValid = ($urandom_range(0, 2) != 0);
            default: begin
                if (imemReq === 1'b1) stallCnt++;
                else stallCnt = 0;
                imemValid = (stallCnt > 3);
            end
        endcase
        if (randSw) switch = 8'($urandom);
        debugSel  = 3'($urandom);
        prevStall = (imemReq === 1'b1) && !imemValid;
        prevAddr  = imemAddr;
        if (m_phase == PH_FETCH) begin
            if (imemValid) begin
                m_instr = imemData;
                m_phase = PH_EXEC;
            end
        end else if (m_phase == PH_EXEC) begin
            model_exec();
        end
    endtask

    task automatic cycle_check();
        chk("pc", 32'(pc), 32'(m_pc));
        chk("halted", 32'(halted), 32'(m_phase == PH_HALT));
        chk("retired", 32'(retired), 32'(m_phase == PH_EXEC));
        chk("imemReq", 32'(imemReq), 32'(m_phase == PH_FETCH));
        if (m_phase == PH_FETCH) chk("imemAddr", 32'(imemAddr), 32'(m_pc));
        if (prevStall && imemReq === 1'b1) chk("addr_stable", 32'(imemAddr), 32'(prevAddr));
        chk("debugValue", 32'(debugValue), 32'(m_regs[debugSel]));
        if (retired === 1'b1) begin
            retireCount++;
            trace.push_back(int'(pc));
        end
    endtask

    // Called at a falling edge; asserts reset between edges and releases later
    task automatic do_reset();
        #2 isResetN = 1'b0;
        #1;
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_retired", 32'(retired), 32'd0);
        chk("rst_imemReq", 32'(imemReq), 32'd0);
        @(negedge clock);
        for (int s = 0; s < 8; s++) begin
            debugSel = 3'(s);
            #1;
            chk("rst_reg", 32'(debugValue), 32'd0);
        end
        model_reset();
        retireCount = 0;
        trace.delete();
        stallCnt  = 0;
        prevStall = 1'b0;
        haltCycle = -1;
        isResetN  = 1'b1;
        #1;
        step_inputs();
    endtask

    task automatic run_prog(input int maxCycles, input bit randRst);
        for (int c = 1; c <= maxCycles; c++) begin
            @(negedge clock);
            cycle_check();
            if (haltCycle < 0 && halted === 1'b1) haltCycle = c;
            if (randRst && (m_phase == PH_HALT || $urandom_range(0, 49) == 0)) do_reset();
            else step_inputs();
        end
    endtask

    task automatic peek(input string name, input int sel, input int exp);
        debugSel = 3'(sel);
        #1;
        chk(name, 32'(debugValue), 32'(exp));
    endtask

    int expTrace [12] = '{8'h00, 8'h08, 8'h09, 8'h0A, 8'h10, 8'h11,
                          8'h12, 8'h13, 8'h40, 8'hFF, 8'h00, 8'h01};

    initial begin
        isResetN  = 1'b0;
        imemValid = 1'b0;
        imemData  = '0;
        switch    = '0;
        debugSel  = '0;
        randSw    = 1'b0;
        vmode     = 0;
        stallCnt  = 0;
        prevStall = 1'b0;
        haltCycle = -1;
        model_reset();
        @(negedge clock);

        // Zero-wait fetch of a tiny program
        clear_rom();
        rom[0] = enc(OP_LOAD, 1, 0, 0, 5);
        rom[1] = enc(OP_INC, 1, 1, 0, 0);
        rom[2] = enc(OP_HALT, 0, 0, 0, 0);
        vmode = 0;
        do_reset();
        run_prog(12, 1'b0);
        peek("t1_r1", 1, 6);
        chk("t1_model_r1", 32'(m_regs[1]), 32'd6);
        chk("t1_halted", 32'(halted), 32'd1);
        chk("t1_pc", 32'(pc), 32'd2);
        chk("t1_retired_count", 32'(retireCount), 32'd3);
        chk("t1_halt_cycle", 32'(haltCycle), 32'd6);

        // Same program with three stall cycles per fetch
        vmode = 2;
        do_reset();
        run_prog(40, 1'b0);
        peek("t2_r1", 1, 6);
        chk("t2_halted", 32'(halted), 32'd1);
        chk("t2_pc", 32'(pc), 32'd2);
        chk("t2_retired_count", 32'(retireCount), 32'd3);

        // Arithmetic wrap and register 0
        clear_rom();
        rom[0] = enc(OP_LOAD, 2, 0, 0, 8'hFF);
        rom[1] = enc(OP_INC, 3, 2, 0, 0);
        rom[2] = enc(OP_DEC, 4, 3, 0, 0);
        rom[3] = enc(OP_SUB, 5, 3, 2, 0);
        rom[4] = enc(OP_LOAD, 0, 0, 0, 8'h55);
        rom[5] = enc(OP_ADD, 0, 2, 2, 0);
        rom[6] = enc(OP_HALT, 0, 0, 0, 0);
        vmode = 1;
        do_reset();
        run_prog(60, 1'b0);
        peek("t3_r3", 3, 8'h00);
        peek("t3_r4", 4, 8'hFF);
        peek("t3_r5", 5, 8'h01);
        peek("t3_r0", 0, 8'h00);
        chk("t3_halted", 32'(halted), 32'd1);

        // Branches, register jump and pc wrap
        clear_rom();
        rom[8'h00] = enc(OP_BZ, 0, 3, 0, 8'h08);
        rom[8'h01] = enc(OP_HALT, 0, 0, 0, 0);
        rom[8'h08] = enc(OP_LOAD, 3, 0, 0, 1);
        rom[8'h09] = enc(OP_LOAD, 1, 0, 0, 0);
        rom[8'h0A] = enc(OP_BZ, 0, 1, 0, 8'h10);
        rom[8'h10] = enc(OP_LOAD, 1, 0, 0, 1);
        rom[8'h11] = enc(OP_BZ, 0, 1, 0, 8'h30);
        rom[8'h12] = enc(OP_LOAD, 2, 0, 0, 8'h40);
        rom[8'h13] = enc(OP_JUMPREG, 0, 0, 2, 0);
        rom[8'h40] = enc(OP_JUMP, 0, 0, 0, 8'hFF);
        vmode = 0;
        do_reset();
        run_prog(40, 1'b0);
        chk("t4_trace_len", 32'(trace.size()), 32'd12);
        for (int i = 0; i < 12 && i < trace.size(); i++) begin
            chk("t4_trace_pc", 32'(trace[i]), 32'(expTrace[i]));
        end
        chk("t4_final_pc", 32'(pc), 32'd1);
        chk("t4_halted", 32'(halted), 32'd1);

        // Switch load and debug read of the top register
        clear_rom();
        rom[0] = enc(OP_LOADSWITCH, 7, 0, 0, 0);
        rom[1] = enc(OP_HALT, 0, 0, 0, 0);
        switch = 8'hA5;
        do_reset();
        run_prog(10, 1'b0);
        peek("t5_r7", 7, 8'hA5);

        // Reset asserted in the middle of an EXEC cycle
        clear_rom();
        rom[0] = enc(OP_LOAD, 1, 0, 0, 5);
        rom[1] = enc(OP_LOAD, 2, 0, 0, 9);
        rom[2] = enc(OP_HALT, 0, 0, 0, 0);
        do_reset();
        run_prog(3, 1'b0);
        chk("t6_in_exec", 32'(retired), 32'd1);
        chk("t6_exec_pc", 32'(pc), 32'd1);
        do_reset();
        run_prog(1, 1'b0);
        peek("t6_no_stale_r2", 2, 0);
        chk("t6_pc_after", 32'(pc), 32'd0);
        run_prog(10, 1'b0);
        peek("t6_rerun_r2", 2, 9);

        // Random programs, random stalls, random switches and random resets
        vmode  = 1;
        randSw = 1'b1;
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 256; i++) rom[i] = {4'($urandom_range(0, 15)), 17'($urandom)};
            do_reset();
            run_prog(300, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
